booth_mul_arbiter: RTL and testbench

- Shares one `booths_multiplier` instance (8x8 signed, start/busy protocol, 16-bit product) among `N_REQ` requesters.
- Arbitrates requests round-robin and sequences the multiplier's start pulse and busy wait.
- Returns each product on a single tagged response channel with a watchdog error path.
- Sits between requesting datapath blocks and the multiplier; it is the only driver of the multiplier's `start`, `a` and `b`.

---
 rtl/booth_mul_arbiter.sv | 174 +++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that shares one start/busy signed multiplier among N_REQ
// requesters and returns each product on a tagged response channel with a watchdog.
module booth_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [2*W-1:0]           rsp_data,
  output logic                     rsp_err,
  output logic                     mul_start,
  output logic [W-1:0]             mul_a,
  output logic [W-1:0]             mul_b,
  input  logic                     mul_busy,
  input  logic [2*W-1:0]           mul_ab
);

  localparam int IDW = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDW-1:0]   r_rr;
  logic [IDW-1:0]   r_id;
  logic [WDW-1:0]   r_wdog;
  logic             r_mul_start;
  logic [W-1:0]     r_mul_a;
  logic [W-1:0]     r_mul_b;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [2*W-1:0]   r_rsp_data;
  logic             r_rsp_err;

  logic             w_any;
  logic [IDW-1:0]   w_gnt;
  logic [IDW:0]     w_sum;
  logic [IDW-1:0]   w_idx;
  logic [IDW-1:0]   w_rr_inc;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic             w_waiting;
  logic             w_timeout;
  logic             w_done;
  logic             w_wd_fire;

  // Scan from rr upward with wrap; iterating high-to-low lets the nearest valid win.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_sum = '0;
    w_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr} + (IDW+1)'(k);
      w_idx = (w_sum >= (IDW+1)'(N_REQ)) ? IDW'(w_sum - (IDW+1)'(N_REQ)) : IDW'(w_sum);
      if (req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  assign w_rr_inc = (w_gnt == IDW'(N_REQ - 1)) ? '0 : w_gnt + 1'b1;
  assign w_sel_a  = req_a[w_gnt*W +: W];
  assign w_sel_b  = req_b[w_gnt*W +: W];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign req_ready[gi] = rst_n && (r_state == S_IDLE) && w_any && (w_gnt == IDW'(gi));
  end

  // A normal completion on the final watchdog cycle still returns the real product.
  assign w_waiting = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
  assign w_timeout = (r_wdog >= WDW'(TIMEOUT - 1));
  assign w_done    = (r_state == S_WAIT_DONE) && !mul_busy;
  assign w_wd_fire = w_waiting && w_timeout && !w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_any) w_state_next = S_ISSUE;
      S_ISSUE:     w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (w_wd_fire) begin
          w_state_next = S_RESP;
        end else if (mul_busy) begin
          w_state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: if (w_done || w_wd_fire) w_state_next = S_RESP;
      S_RESP:      if (rsp_ready) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr        <= '0;
      r_id        <= '0;
      r_wdog      <= '0;
      r_mul_start <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_mul_start <= 1'b1;
            r_mul_a     <= w_sel_a;
            r_mul_b     <= w_sel_b;
            r_id        <= w_gnt;
            r_rr        <= w_rr_inc;
            r_wdog      <= '0;
          end
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          r_wdog <= r_wdog + 1'b1;
          if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= mul_ab;
            r_rsp_err   <= 1'b0;
          end else if (w_wd_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign mul_start = r_mul_start;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a behavioural start/busy multiplier
// that can be switched into a never-busy mode to exercise the watchdog.
module tb_booth_mul_arbiter;
  localparam int N_REQ   = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 5;
  localparam int IDW     = $clog2(N_REQ);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*W-1:0]   req_a;
  logic [N_REQ*W-1:0]   req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [2*W-1:0]       rsp_data;
  logic                 rsp_err;
  logic                 mul_start;
  logic [W-1:0]         mul_a;
  logic [W-1:0]         mul_b;
  logic                 mul_busy;
  logic [2*W-1:0]       mul_ab;

  always #5 clk = ~clk;

  booth_mul_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_busy(mul_busy), .mul_ab(mul_ab)
  );

  // Multiplier model: busy for LAT cycles after start, product valid once busy drops.
  logic mdl_dead = 1'b0;
  int   mdl_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_busy <= 1'b0;
      mdl_cnt  <= 0;
      mul_ab   <= '0;
    end else if (mul_start && !mdl_dead) begin
      mul_busy <= 1'b1;
      mdl_cnt  <= LAT;
    end else if (mul_busy) begin
      if (mdl_cnt == 1) begin
        mul_busy <= 1'b0;
        mul_ab   <= $signed(mul_a) * $signed(mul_b);
      end
      mdl_cnt <= mdl_cnt - 1;
    end
  end

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   n_rsp = 0;
  int   n_start = 0;
  int   n_grant = 0;
  logic prev_start = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int id, input logic [15:0] d, input logic err);
    exp_t e;
    e.id   = id;
    e.data = d;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      n_rsp++;
      $display("rsp id=%0d data=0x%04h err=%0d", rsp_id, rsp_data, rsp_err);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d data=0x%0h, required no response", rsp_id, rsp_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (mul_start) begin
      n_start++;
      check("start_not_back_to_back", 32'(prev_start), 32'd0);
    end
    prev_start = mul_start;
    if (rst_n && |(req_valid & req_ready)) n_grant++;
  end

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id]    = 1'b1;
  endtask

  task automatic wait_grant(input int id, input string name);
    int n = 0;
    @(negedge clk);
    while (!req_ready[id] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(req_ready[id]), 32'd1);
  endtask

  task automatic send(input int id, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp_d, input logic exp_err);
    push_exp(id, exp_d, exp_err);
    set_req(id, a, b);
    wait_grant(id, "grant");
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    @(negedge clk);
    check("mul_start_after_grant", 32'(mul_start), 32'd1);
    check("mul_a", 32'(mul_a), 32'(a));
    check("mul_b", 32'(mul_b), 32'(b));
    @(negedge clk);
    check("mul_start_one_cycle", 32'(mul_start), 32'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] bp_data;
    int          bad;
    int          lat;
    int          n;
    int          g0;

    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    req_valid = '1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, 8'd9, 8'd9, 16'd81, 1'b0);           wait_drain();
    send(2, 8'hFB, 8'd6, 16'hFFE2, 1'b0);        wait_drain();
    send(1, 8'd12, 8'hF9, 16'hFFAC, 1'b0);       wait_drain();
    send(3, 8'hF8, 8'hF8, 16'h0040, 1'b0);       wait_drain();

    // Backpressure: requester 1 waits behind a stalled response from requester 0.
    rsp_ready = 1'b0;
    set_req(1, 8'd2, 8'd5);
    send(0, 8'd3, 8'hFC, 16'hFFF4, 1'b0);
    push_exp(1, 16'd10, 1'b0);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    bp_data = rsp_data;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== bp_data || rsp_id !== 2'd0 || mul_start || req_ready != 0) bad++;
    end
    check("bp_stable_cycles_bad", 32'(bad), 32'd0);
    check("bp_data", 32'(bp_data), 32'hFFF4);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_no_grant_on_accept", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("bp_grant_next_cycle", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_drain();

    // Watchdog: the model never raises busy.
    mdl_dead = 1'b1;
    send(1, 8'd7, 8'd7, 16'd0, 1'b1);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("wd_start_to_rsp_cycles", 32'(lat), 32'(TIMEOUT + 1));
    wait_drain();
    mdl_dead = 1'b0;
    send(2, 8'd4, 8'd5, 16'd20, 1'b0);           wait_drain();

    // Reset while waiting for the multiplier: no response may appear.
    set_req(2, 8'd3, 8'd3);
    wait_grant(2, "rst_op_grant");
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!mul_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_op_busy_seen", 32'(mul_busy), 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    set_req(0, 8'd1, 8'd2);
    set_req(1, 8'hFD, 8'd4);
    set_req(2, 8'd5, 8'hFA);
    set_req(3, 8'd127, 8'h80);
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_data", 32'(rsp_data), 32'd0);
    check("midrst_rsp_id", 32'(rsp_id), 32'd0);
    check("midrst_mul_a", 32'(mul_a), 32'd0);
    check("midrst_mul_b", 32'(mul_b), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin with everyone valid; rr restarts at 0 after reset.
    push_exp(0, 16'h0002, 1'b0);
    push_exp(1, 16'hFFF4, 1'b0);
    push_exp(2, 16'hFFE2, 1'b0);
    push_exp(3, 16'hC080, 1'b0);
    push_exp(0, 16'h0002, 1'b0);
    g0 = n_grant;
    n = 0;
    while (n_grant < g0 + 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rr_grant_count", 32'(n_grant - g0), 32'd5);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();

    check("total_start_pulses", 32'(n_start), 32'd14);
    check("total_responses", 32'(n_rsp), 32'd13);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
